dzcpu_useq: RTL

Micro-op sequencer for the dzcpu core. Latches each fetched opcode byte and maps it to a micro-flow start index through the external opcode LUT, or the CB-prefix LUT after a `jcb` micro-op. It then walks the micro-op ROM one entry per cycle until an end-of-flow code, emitting pc-increment and flag-update strobes and a valid qualifier for the datapath. The block sits between the memory fetch path, the two LUTs, the micro-op ROM and the execute datapath.

---
 rtl/dzcpu_useq_if.sv | 30 +++
 rtl/dzcpu_useq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dzcpu_useq_if.sv
// Bus bundle between the dzcpu micro-op sequencer and its neighbours:
// fetch path, opcode/CB LUTs, micro-op ROM and the execute datapath.
interface dzcpu_useq_if;
  logic [7:0]  iMemData;
  logic        iMemValid;
  logic        iStall;
  logic        iFlagZ;
  logic [7:0]  oMop;
  logic [7:0]  iLutIdx;
  logic [7:0]  iCbLutIdx;
  logic [7:0]  oUopAddr;
  logic [12:0] iUop;
  logic        oUopValid;
  logic        oIncPc;
  logic        oFlagUpdate;
  logic        oEof;
  logic        oHang;

  // Sequencer side
  modport slave (
    input  iMemData, iMemValid, iStall, iFlagZ, iLutIdx, iCbLutIdx, iUop,
    output oMop, oUopAddr, oUopValid, oIncPc, oFlagUpdate, oEof, oHang
  );

  // Environment side (fetch, LUTs, ROM, datapath)
  modport master (
    output iMemData, iMemValid, iStall, iFlagZ, iLutIdx, iCbLutIdx, iUop,
    input  oMop, oUopAddr, oUopValid, oIncPc, oFlagUpdate, oEof, oHang
  );
endinterface

// File: rtl/dzcpu_useq.sv
// dzcpu micro-op sequencer: latches an opcode (or CB byte), dispatches through
// the main or CB LUT and walks the micro-op ROM until an end-of-flow code.
// Optional watchdog enabled by defining DZCPU_USEQ_WDOG_EN; without it oHang is 0.
module dzcpu_useq #(
  parameter logic [4:0] P_JCB_OP     = 5'd22,
  parameter int         P_WDOG_LIMIT = 32
) (
  input  logic         iClock,
  input  logic         iReset,
  dzcpu_useq_if.slave  bus_io
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RUN    = 3'd2,
    S_CBWAIT = 3'd3,
    S_CBDEC  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] mop_q, mop_d;
  logic [7:0] addr_q, addr_d;

  logic [2:0] flow;
  logic [4:0] uop_op;
  logic       run_act;
  logic       uop_inc;
  logic       uop_fu;
  logic       uop_eof;

`ifdef DZCPU_USEQ_WDOG_EN
  localparam int CntW = $clog2(P_WDOG_LIMIT + 1);
  logic [CntW-1:0] wdog_q, wdog_d;
  logic            hang_q, hang_d;
`endif

  assign flow    = bus_io.iUop[12:10];
  assign uop_op  = bus_io.iUop[9:5];
  assign run_act = (state_q == S_RUN) && !bus_io.iStall;

  // Flow-code decode: inc/fu/eof classes; inc_eof_z ends the flow only on Z
  always_comb begin
    uop_inc = 1'b0;
    uop_fu  = 1'b0;
    uop_eof = 1'b0;
    case (flow)
      3'd1: uop_inc = 1'b1;
      3'd2: uop_eof = 1'b1;
      3'd3: begin uop_inc = 1'b1; uop_eof = 1'b1; end
      3'd4: begin uop_fu  = 1'b1; uop_eof = 1'b1; end
      3'd5: begin uop_inc = 1'b1; uop_fu  = 1'b1; uop_eof = 1'b1; end
      3'd6: begin uop_inc = 1'b1; uop_eof = bus_io.iFlagZ; end
      default: ;
    endcase
  end

  // Next-state, opcode latch and ROM address sequencing; a stall freezes all
  always_comb begin
    state_d = state_q;
    mop_d   = mop_q;
    addr_d  = addr_q;
`ifdef DZCPU_USEQ_WDOG_EN
    wdog_d  = wdog_q;
    hang_d  = hang_q;
`endif
    if (!bus_io.iStall) begin
      case (state_q)
        S_FETCH: begin
          if (bus_io.iMemValid) begin
            mop_d   = bus_io.iMemData;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          addr_d  = bus_io.iLutIdx;
          state_d = S_RUN;
`ifdef DZCPU_USEQ_WDOG_EN
          wdog_d  = '0;
`endif
        end
        S_RUN: begin
          // eof beats a jcb dispatch carried by the same word
          if (uop_eof) begin
            state_d = S_FETCH;
          end else if (uop_op == P_JCB_OP) begin
            state_d = S_CBWAIT;
          end else begin
            addr_d = addr_q + 8'd1;
          end
`ifdef DZCPU_USEQ_WDOG_EN
          wdog_d = wdog_q + 1'b1;
          if (!uop_eof && (int'(wdog_q) + 1 >= P_WDOG_LIMIT)) begin
            hang_d  = 1'b1;
            state_d = S_FETCH;
          end
`endif
        end
        S_CBWAIT: begin
          if (bus_io.iMemValid) begin
            mop_d   = bus_io.iMemData;
            state_d = S_CBDEC;
          end
        end
        S_CBDEC: begin
          addr_d  = bus_io.iCbLutIdx;
          state_d = S_RUN;
`ifdef DZCPU_USEQ_WDOG_EN
          wdog_d  = '0;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State register with synchronous reset taking priority over stall
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_FETCH;
      mop_q   <= 8'd0;
      addr_q  <= 8'd0;
`ifdef DZCPU_USEQ_WDOG_EN
      wdog_q  <= '0;
      hang_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mop_q   <= mop_d;
      addr_q  <= addr_d;
`ifdef DZCPU_USEQ_WDOG_EN
      wdog_q  <= wdog_d;
      hang_q  <= hang_d;
`endif
    end
  end

  assign bus_io.oMop        = mop_q;
  assign bus_io.oUopAddr    = addr_q;
  assign bus_io.oUopValid   = run_act;
  assign bus_io.oIncPc      = run_act & uop_inc;
  assign bus_io.oFlagUpdate = run_act & uop_fu;
  assign bus_io.oEof        = run_act & uop_eof;
`ifdef DZCPU_USEQ_WDOG_EN
  assign bus_io.oHang       = hang_q;
`else
  assign bus_io.oHang       = 1'b0;
`endif

endmodule
